// File: rtl/axi_master_arbiter_w.sv
// Write-channel arbiter for two AXI masters sharing one slave port.
// Grants one master at a time, tracks its W beats against the latched AWLEN,
// and flags WLAST placement errors. The grant is released on the B handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; arbitrate any pending AWVALID (round-robin on tie)
//   ADDR  | owner granted, AW handshake pending; W beats may run ahead
//   DATA  | AW accepted, waiting for the WLAST beat
//   RESP  | data phase done, waiting for the B handshake
module axi_master_arbiter_w #(
  parameter int LEN_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             m0_AWVALID,
  input  logic [LEN_W-1:0] m0_AWLEN,
  input  logic             m1_AWVALID,
  input  logic [LEN_W-1:0] m1_AWLEN,
  input  logic             awready,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic             bvalid,
  input  logic             bready,
  output logic             w_m0_wgrnt,
  output logic             w_m1_wgrnt,
  output logic             busy,
  output logic             wlast_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_m1;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat_cnt;
  logic [LEN_W:0]   len_ext;
  logic             wlast_seen;
  logic             req_any;
  logic             pick_m1;
  logic             granted;
  logic             beat;
  logic             aw_hs;
  logic             b_hs;
  logic             beat_err;

  assign req_any = m0_AWVALID | m1_AWVALID;
  // m1 wins when it is the only requester, or on a tie when m0 was served last.
  assign pick_m1 = m1_AWVALID & (~m0_AWVALID | ~last_m1);
  assign granted = w_m0_wgrnt | w_m1_wgrnt;
  assign beat    = wvalid & wready & granted & ((state == ADDR) | (state == DATA));
  assign aw_hs   = (state == ADDR) & awready &
                   ((w_m0_wgrnt & m0_AWVALID) | (w_m1_wgrnt & m1_AWVALID));
  assign b_hs    = (state == RESP) & bvalid & bready;
  assign len_ext = {1'b0, len_q};
  // Missing WLAST fires only at the exact final beat, so overrun beats stay quiet.
  assign beat_err = beat & (((beat_cnt == len_ext) & ~wlast) |
                            (wlast & (beat_cnt < len_ext)));

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_any) state_nxt = ADDR;
      ADDR: if (aw_hs) state_nxt = (wlast_seen | (beat & wlast)) ? RESP : DATA;
      DATA: if (beat & wlast) state_nxt = RESP;
      RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with busy registered alongside it.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Grant issue/release and the round-robin pointer.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_m0_wgrnt <= 1'b0;
      w_m1_wgrnt <= 1'b0;
      last_m1    <= 1'b1;
    end else if ((state == IDLE) && req_any) begin
      w_m0_wgrnt <= ~pick_m1;
      w_m1_wgrnt <= pick_m1;
    end else if (b_hs) begin
      w_m0_wgrnt <= 1'b0;
      w_m1_wgrnt <= 1'b0;
      last_m1    <= w_m1_wgrnt;
    end
  end

  // Burst bookkeeping: latched length, beat count, early-WLAST flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      wlast_seen <= 1'b0;
    end else if ((state == IDLE) && req_any) begin
      len_q      <= pick_m1 ? m1_AWLEN : m0_AWLEN;
      beat_cnt   <= '0;
      wlast_seen <= 1'b0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + (LEN_W+1)'(1);
      if (wlast && (state == ADDR)) wlast_seen <= 1'b1;
    end
  end

  // One-cycle error pulse following the offending beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) wlast_err <= 1'b0;
    else          wlast_err <= beat_err;
  end

endmodule

// File: tb/tb_axi_master_arbiter_w.sv
// Bench for axi_master_arbiter_w: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_axi_master_arbiter_w;
  localparam int LEN_W = 8;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             m0_AWVALID = 1'b0;
  logic [LEN_W-1:0] m0_AWLEN = '0;
  logic             m1_AWVALID = 1'b0;
  logic [LEN_W-1:0] m1_AWLEN = '0;
  logic             awready = 1'b0;
  logic             wvalid = 1'b0;
  logic             wready = 1'b0;
  logic             wlast = 1'b0;
  logic             bvalid = 1'b0;
  logic             bready = 1'b0;
  logic             w_m0_wgrnt;
  logic             w_m1_wgrnt;
  logic             busy;
  logic             wlast_err;

  axi_master_arbiter_w #(.LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(m0_AWVALID), .m0_AWLEN(m0_AWLEN),
    .m1_AWVALID(m1_AWVALID), .m1_AWLEN(m1_AWLEN),
    .awready(awready), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
    .w_m0_wgrnt(w_m0_wgrnt), .w_m1_wgrnt(w_m1_wgrnt),
    .busy(busy), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=m0 2=m1; a transaction is the pair of
  // facts "address accepted" and "data finished", released by B.
  int mo_owner = 0;
  int mo_last = 2;
  int mo_len = 0;
  int mo_beats = 0;
  bit mo_aw = 0;
  bit mo_dd = 0;
  bit mo_err = 0;

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      mo_owner = 0; mo_last = 2; mo_len = 0; mo_beats = 0;
      mo_aw = 0; mo_dd = 0; mo_err = 0;
    end else begin
      mo_err = 0;
      if (mo_owner == 0) begin
        if (m0_AWVALID && m1_AWVALID) mo_owner = (mo_last == 1) ? 2 : 1;
        else if (m0_AWVALID)          mo_owner = 1;
        else if (m1_AWVALID)          mo_owner = 2;
        if (mo_owner != 0) begin
          mo_len   = (mo_owner == 1) ? int'(m0_AWLEN) : int'(m1_AWLEN);
          mo_beats = 0; mo_aw = 0; mo_dd = 0;
        end
      end else if (mo_aw && mo_dd) begin
        if (bvalid && bready) begin
          mo_last  = mo_owner;
          mo_owner = 0;
        end
      end else begin
        bit awv;
        awv = (mo_owner == 1) ? m0_AWVALID : m1_AWVALID;
        if (wvalid && wready) begin
          if ((mo_beats == mo_len && !wlast) || (wlast && mo_beats < mo_len)) mo_err = 1;
          mo_beats++;
          if (wlast) mo_dd = 1;
        end
        if (!mo_aw && awv && awready) mo_aw = 1;
      end
    end
    #1;
    check("grant", {w_m1_wgrnt, w_m0_wgrnt}, {mo_owner == 2, mo_owner == 1});
    check("busy", busy, mo_owner != 0);
    check("wlast_err", wlast_err, mo_err);
    if (wlast_err === 1'b1) err_pulses++;
  end

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic aw_hs();
    awready = 1'b1; cyc(); awready = 1'b0;
  endtask

  task automatic beat(input bit last);
    wvalid = 1'b1; wready = 1'b1; wlast = last;
    cyc();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_hs();
    bvalid = 1'b1; bready = 1'b1; cyc(); bvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic wait_grant(output int m, output int waited);
    m = -1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_m0_wgrnt === 1'b1 || w_m1_wgrnt === 1'b1) break;
      cyc();
      waited++;
    end
    if (w_m0_wgrnt === 1'b1)      m = 0;
    else if (w_m1_wgrnt === 1'b1) m = 1;
    else begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: no grant after %0d cycles, required a grant", waited);
    end
  endtask

  initial begin
    int g, w, base;

    // Reset and reset-state checks.
    ARESETn = 1'b0;
    repeat (3) cyc();
    ARESETn = 1'b1;
    check("rst_grant", {w_m1_wgrnt, w_m0_wgrnt}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", wlast_err, 1'b0);

    // Simultaneous request after reset: m0 first, then m1.
    base = err_pulses;
    m0_AWVALID = 1'b1; m1_AWVALID = 1'b1; m0_AWLEN = 8'd3; m1_AWLEN = 8'd3;
    wait_grant(g, w);
    check("s1_first_m", g, 0);
    check("s1_first_lat", w, 1);
    aw_hs();
    for (int b = 1; b <= 4; b++) beat(b == 4);
    b_hs();
    check("s1_grant_after_b", {w_m1_wgrnt, w_m0_wgrnt}, 2'b00);
    wait_grant(g, w);
    check("s1_second_m", g, 1);
    check("s1_second_lat", w, 1);
    aw_hs();
    m0_AWVALID = 1'b0; m1_AWVALID = 1'b0;
    for (int b = 1; b <= 4; b++) beat(b == 4);
    b_hs();
    check("s1_errs", err_pulses - base, 0);
    repeat (2) cyc();

    // Round-robin over four single-beat transactions.
    m0_AWVALID = 1'b1; m1_AWVALID = 1'b1; m0_AWLEN = 8'd0; m1_AWLEN = 8'd0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, w);
      check("s2_rr_m", g, k % 2);
      aw_hs();
      beat(1'b1);
      if (k == 3) begin m0_AWVALID = 1'b0; m1_AWVALID = 1'b0; end
      b_hs();
    end
    check("s2_errs", err_pulses - base, 0);
    repeat (2) cyc();

    // Early WLAST: AWLEN=7, wlast on beat 3.
    base = err_pulses;
    m0_AWVALID = 1'b1; m0_AWLEN = 8'd7;
    wait_grant(g, w);
    check("s3_m", g, 0);
    aw_hs();
    m0_AWVALID = 1'b0;
    beat(1'b0); beat(1'b0); beat(1'b1);
    check("s3_err_hi", wlast_err, 1'b1);
    check("s3_grant_held", {w_m1_wgrnt, w_m0_wgrnt}, 2'b01);
    cyc();
    check("s3_err_lo", wlast_err, 1'b0);
    check("s3_busy_resp", busy, 1'b1);
    b_hs();
    check("s3_idle", busy, 1'b0);
    check("s3_errs", err_pulses - base, 1);

    // Missing WLAST: AWLEN=1, wlast on beat 4.
    base = err_pulses;
    m1_AWVALID = 1'b1; m1_AWLEN = 8'd1;
    wait_grant(g, w);
    check("s4_m", g, 1);
    aw_hs();
    m1_AWVALID = 1'b0;
    beat(1'b0); beat(1'b0);
    check("s4_err_hi", wlast_err, 1'b1);
    beat(1'b0);
    check("s4_err_lo", wlast_err, 1'b0);
    b_hs();
    check("s4_still_data", busy, 1'b1);
    beat(1'b1);
    b_hs();
    check("s4_idle", busy, 1'b0);
    check("s4_errs", err_pulses - base, 1);

    // W before AW: both beats land in ADDR, AW handshake goes straight to RESP.
    base = err_pulses;
    m0_AWVALID = 1'b1; m0_AWLEN = 8'd1;
    wait_grant(g, w);
    check("s5_m", g, 0);
    beat(1'b0); beat(1'b1);
    check("s5_busy_addr", busy, 1'b1);
    aw_hs();
    m0_AWVALID = 1'b0;
    b_hs();
    check("s5_idle", busy, 1'b0);

    // AW handshake and WLAST beat in the same cycle.
    m1_AWVALID = 1'b1; m1_AWLEN = 8'd0;
    wait_grant(g, w);
    check("s5b_m", g, 1);
    awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    cyc();
    awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    m1_AWVALID = 1'b0;
    b_hs();
    check("s5b_idle", busy, 1'b0);
    check("s5_errs", err_pulses - base, 0);

    // Reset during DATA after beat 2 of 4.
    base = err_pulses;
    m0_AWVALID = 1'b1; m0_AWLEN = 8'd3;
    wait_grant(g, w);
    aw_hs();
    m0_AWVALID = 1'b0;
    beat(1'b0); beat(1'b0);
    ARESETn = 1'b0;
    cyc();
    check("s6_rst_grant", {w_m1_wgrnt, w_m0_wgrnt}, 2'b00);
    check("s6_rst_busy", busy, 1'b0);
    check("s6_rst_err", wlast_err, 1'b0);
    ARESETn = 1'b1;
    m0_AWVALID = 1'b1; m1_AWVALID = 1'b1; m1_AWLEN = 8'd3;
    wait_grant(g, w);
    check("s6_regrant_m", g, 0);
    check("s6_regrant_lat", w, 1);
    aw_hs();
    m0_AWVALID = 1'b0; m1_AWVALID = 1'b0;
    for (int b = 1; b <= 4; b++) beat(b == 4);
    b_hs();
    check("s6_idle", busy, 1'b0);
    check("s6_errs", err_pulses - base, 0);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_master_arbiter_w.md
AXI_MASTER_ARBITER_W -- requirements
Module: axi_master_arbiter_w

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, which sets the AWLEN width.
REQ-002 Port ACLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port ARESETn, input, 1 bit: the reset, which SHALL be synchronous and active-low.
REQ-004 Port m0_AWVALID, input, 1 bit: master 0 write-address request.
REQ-005 Port m0_AWLEN, input, LEN_W bits: master 0 burst length minus one.
REQ-006 Port m1_AWVALID, input, 1 bit: master 1 write-address request.
REQ-007 Port m1_AWLEN, input, LEN_W bits: master 1 burst length minus one.
REQ-008 Port awready, input, 1 bit: slave-side AW ready.
REQ-009 Ports wvalid, wready and wlast, inputs, 1 bit each: the muxed W channel as driven by the write-data mux and the slave.
REQ-010 Ports bvalid and bready, inputs, 1 bit each: the B channel handshake.
REQ-011 Ports w_m0_wgrnt and w_m1_wgrnt, outputs, 1 bit each, registered: write grants to the W mux.
REQ-012 Port busy, output, 1 bit, registered: high when the state is not IDLE.
REQ-013 Port wlast_err, output, 1 bit, registered: one-cycle pulse on a WLAST/AWLEN mismatch.

Function
REQ-014 The grant pair SHALL be either 2'b00 or one-hot; 2'b11 SHALL never occur.
REQ-015 The FSM SHALL have four states, IDLE, ADDR, DATA and RESP, and SHALL be one-hot or binary-encoded.
REQ-016 In IDLE, when at least one AWVALID is high, the FSM SHALL move to ADDR and assert exactly one grant on the next edge.
- If only one master is requesting, that master SHALL be granted.
- If both masters are requesting, the master not granted last time SHALL win (round-robin).
REQ-017 On grant, the winning master's AWLEN SHALL be latched into len_q, the beat counter SHALL clear, and wlast_seen SHALL clear.
REQ-018 While any state other than IDLE is active, the grant SHALL hold steady; a new AWVALID from either master SHALL be ignored.
REQ-019 A W beat is wvalid&&wready while a grant is active; each beat SHALL increment the beat counter (LEN_W+1 bits, no wrap for legal bursts) in ADDR and DATA alike.
REQ-020 In ADDR, the AW handshake (granted master's AWVALID && awready) SHALL cause a transition to RESP if wlast_seen=1, otherwise to DATA.
REQ-021 In ADDR, a beat with wlast=1 SHALL set wlast_seen and SHALL leave the state at ADDR.
REQ-022 In DATA, a beat with wlast=1 SHALL cause a transition to RESP.
REQ-023 A beat whose pre-increment count equals len_q SHALL carry wlast=1; otherwise wlast_err SHALL pulse on the following cycle.
REQ-024 A beat with wlast=1 whose count is less than len_q SHALL pulse wlast_err and SHALL still end the data phase.
REQ-025 After a missing-WLAST error, the FSM SHALL stay in DATA until wlast=1 arrives, with no further error pulses.
REQ-026 In RESP, bvalid&&bready SHALL cause a transition to IDLE; grants SHALL drop on that edge, and the last-granted pointer SHALL record the served master.
REQ-027 The minimum transaction occupancy SHALL be: grant 1 cycle after AWVALID in IDLE, and 0 grant cycles after the B handshake.
REQ-028 When an AW handshake and a wlast beat occur in the same ADDR cycle, the FSM SHALL go directly to RESP.
REQ-029 When bvalid&&bready and a new AWVALID coincide in RESP, the FSM SHALL go to IDLE first; re-arbitration SHALL occur on the next cycle, using the updated pointer.

Reset
REQ-030 When ARESETn=0 at a rising edge, the block SHALL set state=IDLE, both grants=0, busy=0, wlast_err=0, counter=0, len_q=0 and wlast_seen=0, and SHALL point last-grant at m1 so that m0 wins the first tie.
REQ-031 Reset asserted mid-transaction SHALL drop grants on that same edge, with no error pulse; operation SHALL resume from IDLE on the first edge with ARESETn=1.

Verification
REQ-032 Simultaneous request after reset: both AWVALID=1 with AWLEN=3 and 4 beats with wlast on beat 4 -> m0 is granted the cycle after the request, there is no wlast_err, grants=00 after B, then m1 is granted.
REQ-033 Alternating round-robin: both masters hold AWVALID for 4 single-beat transactions -> grants go m0, m1, m0, m1.
REQ-034 Early WLAST: AWLEN=7 with wlast on beat 3 -> wlast_err is high for exactly 1 cycle after beat 3, and the state is RESP.
REQ-035 Missing WLAST: AWLEN=1 with wlast on beat 4 -> one wlast_err pulse after beat 2, the FSM stays in DATA until beat 4, then goes to RESP.
REQ-036 W before AW: all 2 beats, including wlast, are accepted before awready -> after the AW handshake the state goes straight to RESP, with no error.
REQ-037 Reset during DATA: ARESETn=0 after beat 2 of 4 -> grants=00 and busy=0 on the next edge, and the next request is granted normally.
